serpent_key_sched: RTL and testbench
====================================

Name: serpent_key_sched

Overview:
- Serpent key-schedule engine. Expands a 128/192/256-bit user key into the 33 bitsliced 128-bit round keys.
- Acts as the writer for the round-key memory: one write per round key, at addresses 0..32, over a write-enable/address/data port.
- Sits between the XTS key-load control and the round-key memory. The cipher core reads keys only after o_done.

Parameters:
- N_ROUNDKEYS, 33, number of round keys generated and written (fixed for Serpent; changing it is unsupported).
- PHI, 32'h9E3779B9, golden-ratio constant used in prekey recurrence.

Ports:
- i_clk  input  1  clock; all logic on rising edge.
- i_rst  input  1  reset; synchronous, active-high. Clears all state and outputs on the next edge.
- i_start  input  1  start request; sampled only in IDLE.
- i_key  input  256  user key; word j = i_key[32j+31:32j]; bits above key length ignored.
- i_key_len  input  2  0=128-bit, 1=192-bit, 2 or 3=256-bit.
- o_busy  output  1  high while generating.
- o_done  output  1  one-cycle pulse after the last write.
- o_mem_we  output  1  round-key write strobe.
- o_mem_addr  output  6  round-key index 0..32.
- o_mem_key  output  128  round key data.

Behaviour:
- Reset values: o_busy=0, o_done=0, o_mem_we=0, o_mem_addr=0, o_mem_key=0, FSM=IDLE, all counters and the window register cleared.
- FSM states: IDLE, GEN, WRITE, DONE.
- IDLE: on i_start=1, load an 8-word window W[-8..-1] from i_key with padding applied, clear word index i and key index k, then go to GEN.
- Padding:
  - 128-bit: bit 128 set, bits 255:129 zero.
  - 192-bit: bit 192 set, bits 255:193 zero.
  - 256-bit: key used unchanged.
- GEN: one prekey word per cycle.
  - w_i = ROTL11(w_{i-8} ^ w_{i-5} ^ w_{i-3} ^ w_{i-1} ^ PHI ^ i), with i as a 32-bit value.
  - Window shifts by one word; w_i is captured into a 4-word group register.
  - After 4 words (i = 4k+3), go to WRITE.
- WRITE (one cycle):
  - Apply S-box S_{(3-k) mod 8} bitsliced to group (x0..x3) = (w4k..w4k+3). For each bit b in 0..31, nibble {x3[b],x2[b],x1[b],x0[b]} maps to {y3[b],y2[b],y1[b],y0[b]}.
  - No IP/FP permutation (bitslice domain).
  - Drive o_mem_we=1, o_mem_addr=k, o_mem_key={y3,y2,y1,y0}.
  - Increment k. If k was 32, go to DONE; else go to GEN.
- DONE: o_done=1 for exactly one cycle, o_busy=0, then IDLE.
- o_mem_we is high only in WRITE. o_mem_addr/o_mem_key hold their last value otherwise.
- Timing, taking the edge sampling i_start as cycle 0:
  - o_busy high cycles 1..165.
  - Key k written in cycle 5k+5, so writes occur at 5, 10, …, 165.
  - o_done in cycle 166.
  - Next i_start accepted in cycle 167.
- i_start while busy or in DONE is ignored; no queueing.
- i_key/i_key_len are sampled only at start; later changes have no effect on the run in progress.
- i_rst mid-run: next edge returns to IDLE with all outputs zero. No further writes; o_done is not pulsed. Partially written keys are left in memory; consumers rely on o_done only.
- i_rst and i_start in the same cycle: reset wins.
- Word index i runs 0..131; k runs 0..32; no wrap.

Test Plan:
- Zero 128-bit key, pulse i_start -> exactly 33 o_mem_we pulses at cycles 5,10,…,165 with addr 0..32 in order; o_done only at cycle 166; o_busy high cycles 1..165; internal w0 = 32'hBBCDCCF1.
- 128-bit key 0 vs 256-bit key with only bit 128 set -> all 33 o_mem_key values identical between runs.
- Random keys of 128/192/256 bits -> every o_mem_key matches a bitsliced software Serpent key-schedule model (no IP), 100 keys per length.
- i_start re-pulsed at cycles 3 and 80 of a run -> ignored; write sequence and o_done timing unchanged; a new start at cycle 167 produces a fresh 33-write run.
- i_rst asserted at cycle 50 -> from cycle 51 all outputs 0 and no further writes; no o_done; a subsequent start yields a full correct run.
- i_rst and i_start high together in IDLE -> remains IDLE, o_busy stays 0.

Source files
------------

// File: rtl/serpent_key_sched_if.sv
// Control and round-key memory write bus of the Serpent key-schedule engine.
// The key-load controller is the master; the schedule engine is the slave.
interface serpent_key_sched_if;
  logic         i_start;
  logic [255:0] i_key;
  logic [1:0]   i_key_len;
  logic         o_busy;
  logic         o_done;
  logic         o_mem_we;
  logic [5:0]   o_mem_addr;
  logic [127:0] o_mem_key;

  modport master (
    output i_start, i_key, i_key_len,
    input  o_busy, o_done, o_mem_we, o_mem_addr, o_mem_key
  );

  modport slave (
    input  i_start, i_key, i_key_len,
    output o_busy, o_done, o_mem_we, o_mem_addr, o_mem_key
  );
endinterface

// File: rtl/serpent_key_sched.sv
// Serpent key schedule: expands a padded 128/192/256-bit user key into 33
// bitsliced round keys, one prekey word per cycle, one memory write per key.
module serpent_key_sched #(
  parameter int          N_ROUNDKEYS = 33,
  parameter logic [31:0] PHI         = 32'h9E3779B9
) (
  input  logic                i_clk,
  input  logic                i_rst,
  serpent_key_sched_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_GEN, S_WRITE, S_DONE} state_t;

  localparam logic [5:0] LAST_K = 6'(N_ROUNDKEYS - 1);

  state_t        r_state;
  logic [31:0]   r_win [8];
  logic [31:0]   r_grp [4];
  logic [7:0]    r_wi;
  logic [5:0]    r_k;
  logic          r_busy;
  logic          r_done;
  logic          r_we;
  logic [5:0]    r_addr;
  logic [127:0]  r_key;

  logic [255:0]  w_pad;
  logic [31:0]   w_next;
  logic [2:0]    w_sel;
  logic [31:0]   w_y0, w_y1, w_y2, w_y3;

  function automatic logic [31:0] rotl11(input logic [31:0] x);
    return {x[20:0], x[31:21]};
  endfunction

  // Each table holds entry n in nibble n (bits 4n+3..4n).
  function automatic logic [3:0] sbox(input logic [2:0] sel, input logic [3:0] x);
    logic [63:0] t;
    case (sel)
      3'd0:    t = 64'hC90724DEB56A1F83;
      3'd1:    t = 64'h43D68EB1A50972CF;
      3'd2:    t = 64'h25B04E1DFAC39768;
      3'd3:    t = 64'hE57A421D369C8BF0;
      3'd4:    t = 64'hD7E9A4526B0C38F1;
      3'd5:    t = 64'h176D8E30C9A4B25F;
      3'd6:    t = 64'h0A3DF19EB6485C27;
      default: t = 64'h6539AC47B28E0FD1;
    endcase
    return t[{x, 2'b00} +: 4];
  endfunction

  always_comb begin
    w_pad = bus.i_key;
    case (bus.i_key_len)
      2'd0: begin
        w_pad[255:128] = '0;
        w_pad[128]     = 1'b1;
      end
      2'd1: begin
        w_pad[255:192] = '0;
        w_pad[192]     = 1'b1;
      end
      default: ;
    endcase
  end

  // Window slot 0 holds w[i-8], slot 7 holds w[i-1].
  assign w_next = rotl11(r_win[0] ^ r_win[3] ^ r_win[5] ^ r_win[7] ^ PHI ^ {24'd0, r_wi});

  // Round key k uses S-box (3 - k) mod 8.
  assign w_sel = 3'd3 - r_k[2:0];

  always_comb begin
    w_y0 = '0;
    w_y1 = '0;
    w_y2 = '0;
    w_y3 = '0;
    for (int b = 0; b < 32; b++) begin
      {w_y3[b], w_y2[b], w_y1[b], w_y0[b]} =
        sbox(w_sel, {r_grp[3][b], r_grp[2][b], r_grp[1][b], r_grp[0][b]});
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_wi    <= '0;
      r_k     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_key   <= '0;
      for (int j = 0; j < 8; j++) r_win[j] <= '0;
      for (int j = 0; j < 4; j++) r_grp[j] <= '0;
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_busy <= 1'b0;
          if (bus.i_start) begin
            for (int j = 0; j < 8; j++) r_win[j] <= w_pad[32*j +: 32];
            r_wi    <= '0;
            r_k     <= '0;
            r_state <= S_GEN;
          end
        end
        S_GEN: begin
          r_busy <= 1'b1;
          for (int j = 0; j < 7; j++) r_win[j] <= r_win[j+1];
          r_win[7]          <= w_next;
          r_grp[r_wi[1:0]]  <= w_next;
          r_wi              <= r_wi + 8'd1;
          if (r_wi[1:0] == 2'd3) r_state <= S_WRITE;
        end
        S_WRITE: begin
          r_busy <= 1'b1;
          r_we   <= 1'b1;
          r_addr <= r_k;
          r_key  <= {w_y3, w_y2, w_y1, w_y0};
          if (r_k == LAST_K) begin
            r_state <= S_DONE;
          end else begin
            r_k     <= r_k + 6'd1;
            r_state <= S_GEN;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.o_busy     = r_busy;
  assign bus.o_done     = r_done;
  assign bus.o_mem_we   = r_we;
  assign bus.o_mem_addr = r_addr;
  assign bus.o_mem_key  = r_key;

endmodule

// File: tb/tb_serpent_key_sched.sv
// Randomised bench for serpent_key_sched against an array-based model of the
// Serpent prekey recurrence and bitsliced S-box round-key derivation.
module tb_serpent_key_sched;

  localparam logic [31:0] PHI = 32'h9E3779B9;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serpent_key_sched_if bus ();

  serpent_key_sched dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int SB [8][16] = '{
    '{ 3,  8, 15,  1, 10,  6,  5, 11, 14, 13,  4,  2,  7,  0,  9, 12},
    '{15, 12,  2,  7,  9,  0,  5, 10,  1, 11, 14,  8,  6, 13,  3,  4},
    '{ 8,  6,  7,  9,  3, 12, 10, 15, 13,  1, 14,  4,  0, 11,  5,  2},
    '{ 0, 15, 11,  8, 12,  9,  6,  3, 13,  1,  2,  4, 10,  7,  5, 14},
    '{ 1, 15,  8,  3, 12,  0, 11,  6,  2,  5,  4, 10,  9, 14,  7, 13},
    '{15,  5,  2, 11,  4, 10,  9, 12,  0,  3, 14,  8, 13,  6,  7,  1},
    '{ 7,  2, 12,  5,  8,  4,  6, 11, 14,  9,  1, 15, 13,  3, 10,  0},
    '{ 1, 13, 15,  0, 14,  8,  2, 11,  7,  4, 12, 10,  9,  3,  5,  6}
  };

  logic [127:0] exp_keys [33];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [255:0] key, input logic [1:0] len);
    logic [31:0]  w [140];
    logic [255:0] k;
    logic [31:0]  t;
    int s, x, y;
    k = key;
    if (len == 2'd0) begin
      k[255:128] = '0;
      k[128]     = 1'b1;
    end else if (len == 2'd1) begin
      k[255:192] = '0;
      k[192]     = 1'b1;
    end
    for (int j = 0; j < 8; j++) w[j] = k[32*j +: 32];
    for (int i = 0; i < 132; i++) begin
      t = w[i] ^ w[i+3] ^ w[i+5] ^ w[i+7] ^ PHI ^ 32'(i);
      w[i+8] = (t << 11) | (t >> 21);
    end
    for (int kk = 0; kk < 33; kk++) begin
      s = (35 - kk) % 8;
      exp_keys[kk] = '0;
      for (int b = 0; b < 32; b++) begin
        x = 8 * int'(w[8+4*kk+3][b]) + 4 * int'(w[8+4*kk+2][b])
          + 2 * int'(w[8+4*kk+1][b]) + int'(w[8+4*kk][b]);
        y = SB[s][x];
        exp_keys[kk][b]      = y[0];
        exp_keys[kk][32+b]   = y[1];
        exp_keys[kk][64+b]   = y[2];
        exp_keys[kk][96+b]   = y[3];
      end
    end
  endtask

  // Starts a run from IDLE (called at a negedge) and checks every cycle of it.
  task automatic do_run(input logic [255:0] key, input logic [1:0] len,
                        input bit glitch, input int rst_at, input bit chk_w0);
    int  n_cyc;
    bit  live;
    logic [255:0] junk;
    model(key, len);
    n_cyc = (rst_at >= 0) ? rst_at + 10 : 166;
    bus.i_key     = key;
    bus.i_key_len = len;
    bus.i_start   = 1'b1;
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    for (int j = 0; j < 8; j++) junk[32*j +: 32] = $urandom();
    bus.i_key     = junk;
    bus.i_key_len = 2'($urandom_range(0, 3));
    for (int c = 1; c <= n_cyc; c++) begin
      @(posedge clk);
      #1;
      bus.i_start = glitch && (c == 3 || c == 80);
      rst         = (c == rst_at);
      @(negedge clk);
      live = (rst_at < 0) || (c <= rst_at);
      if (chk_w0 && c == 1) check("w0", {96'd0, dut.r_grp[0]}, {96'd0, 32'hBBCDCCF1});
      check("busy", bus.o_busy, live && c >= 1 && c <= 165);
      check("done", bus.o_done, live && c == 166);
      check("we",   bus.o_mem_we, live && (c % 5 == 0) && c <= 165);
      if (live && (c % 5 == 0) && c <= 165) begin
        check("addr", bus.o_mem_addr, 128'(c / 5 - 1));
        check("key",  bus.o_mem_key,  exp_keys[c / 5 - 1]);
      end else if (!live) begin
        check("addr_rst", bus.o_mem_addr, 128'd0);
        check("key_rst",  bus.o_mem_key,  128'd0);
      end
    end
  endtask

  function automatic logic [255:0] rand_key();
    logic [255:0] k;
    for (int j = 0; j < 8; j++) k[32*j +: 32] = $urandom();
    return k;
  endfunction

  initial begin
    rst           = 1'b1;
    bus.i_start   = 1'b0;
    bus.i_key     = '0;
    bus.i_key_len = 2'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", bus.o_busy, 1'b0);
    check("rst_done", bus.o_done, 1'b0);
    check("rst_we",   bus.o_mem_we, 1'b0);
    check("rst_addr", bus.o_mem_addr, 128'd0);
    check("rst_key",  bus.o_mem_key, 128'd0);
    rst = 1'b0;

    // Zero 128-bit key, then the equivalent 256-bit key with only bit 128 set.
    do_run(256'd0, 2'd0, 1'b0, -1, 1'b1);
    do_run(256'd1 << 128, 2'd2, 1'b0, -1, 1'b0);

    // Stray starts during a run, then back-to-back start at cycle 167.
    do_run(rand_key(), 2'd1, 1'b1, -1, 1'b0);
    do_run(rand_key(), 2'd3, 1'b0, -1, 1'b0);

    // Reset in the middle of a run, then a clean run.
    do_run(rand_key(), 2'd2, 1'b0, 50, 1'b0);
    do_run(rand_key(), 2'd0, 1'b0, -1, 1'b0);

    // Reset and start together while idle.
    rst         = 1'b1;
    bus.i_start = 1'b1;
    @(posedge clk);
    #1;
    rst         = 1'b0;
    bus.i_start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rststart_busy", bus.o_busy, 1'b0);
      check("rststart_we",   bus.o_mem_we, 1'b0);
      @(posedge clk);
    end
    @(negedge clk);

    for (int len = 0; len < 3; len++) begin
      for (int r = 0; r < 100; r++) begin
        logic [1:0] l;
        l = (len == 2) ? 2'($urandom_range(2, 3)) : 2'(len);
        do_run(rand_key(), l, 1'b0, -1, 1'b0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
